ps2_key_cmd: RTL
================

Name: ps2_key_cmd

Overview:
Downstream consumer of the PS/2 keyboard decoder (`ps2`). It takes the decoder's level outputs (up/down/left/right/enter, high while the key is held) and turns them into game commands:
- a latched 2-bit direction code;
- a one-cycle step pulse on each press, with typematic-style auto-repeat;
- a one-cycle enter pulse.

It feeds the game-logic/movement FSM, which advances the player only on step_pulse.

Parameters:
REPEAT_DELAY, 50_000_000, cycles from a press pulse to the first auto-repeat pulse (500 ms at 100 MHz); must be >= 1
REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat pulses (100 ms at 100 MHz); must be >= 1
CNT_W, 26, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)-1

Ports:
clk  in  1  system clock, 100 MHz, single clock domain
rst  in  1  synchronous reset, active-high
up  in  1  W held (level, from ps2)
down  in  1  S held
left  in  1  A held
right  in  1  D held
enter  in  1  Enter held
rep_en  in  1  1 = auto-repeat enabled; 0 = press pulses only
dir_o  out  2  active direction: 00 up, 01 down, 10 left, 11 right
dir_valid  out  1  high while an active direction key is held
step_pulse  out  1  one-cycle move command
enter_pulse  out  1  one-cycle enter command

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
- Reset values:
  - dir_o=00, dir_valid=0, step_pulse=0, enter_pulse=0.
  - FSM=IDLE, counter=0.
  - Previous-key register k_q=00000.
- Edge detection:
  - k_q registers {up,down,left,right,enter} every cycle.
  - rise = key & ~k_q; fall = ~key & k_q.
  - All outputs are registered. A pulse is high for exactly the one cycle after the edge at which the key is first sampled high (latency 1 cycle).
- Priority: when several directions rise in the same cycle, or a fallback must be chosen, the order is up > down > left > right.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE, any direction rise: dir_o <= highest-priority rising key; step_pulse=1; counter=0; -> DELAY.
  - DELAY, counter==REPEAT_DELAY-1 and rep_en=1: step_pulse=1; counter=0; -> REPEAT. Otherwise the counter increments.
  - REPEAT, counter==REPEAT_RATE-1 and rep_en=1: step_pulse=1; counter=0; stay in REPEAT.
  - rep_en=0 in DELAY/REPEAT: counter holds and no repeat pulses occur. rep_en returning to 1 resumes the count from the held value.
  - DELAY/REPEAT, rise on a different direction (newest key wins): dir_o <= that key (priority if several rise); step_pulse=1; counter=0; -> DELAY.
  - DELAY/REPEAT, fall of the active key with another direction still held: dir_o <= highest-priority held key; step_pulse=1; counter=0; -> DELAY.
  - DELAY/REPEAT, fall of the active key with none held: -> IDLE, no pulse. dir_o retains its last value.
  - Fall of a non-active key: ignored.
  - Rise and fall in the same cycle: rise handling takes precedence.
- dir_valid = (state != IDLE), registered.
- Counter never wraps; it is always cleared on reaching its terminal count.
- enter_pulse:
  - one cycle per enter rise; never repeats;
  - independent of the FSM;
  - may coincide with step_pulse.
- Reset mid-operation:
  - outputs return to reset values immediately on the next edge;
  - a key still held when rst deasserts counts as a new press: pulse on the first post-reset cycle, because k_q=0.

Decomposition:
- Package ps2_cmd_pkg:
  - DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11;
  - FSM state encoding IDLE/DELAY/REPEAT;
  - priority-encode function (4-bit held vector -> 2-bit code).
- Sub-module key_edge_det (parameter W=5): registered k_q plus rise/fall vectors. It is instantiated once and reused by the movement FSM.

Test Plan (REPEAT_DELAY=8, REPEAT_RATE=4, rep_en=1 unless stated):
1. Reset, then pulse up for 1 cycle -> step_pulse high exactly 1 cycle, 1 cycle after the rise. dir_o=00; dir_valid high 1 cycle then low. No repeat.
2. Hold right for 30 cycles -> step_pulse at offsets 1, 9, 13, 17, 21, 25, 29 from the rise; dir_o=11. On release, dir_valid drops next cycle with no pulse.
3. Hold left, assert up 3 cycles later -> extra pulse with dir_o=00, repeat timer restarts (next pulse 8 cycles later). Release up while left is held -> pulse with dir_o=10.
4. down and right rise in the same cycle -> a single pulse with dir_o=01. Release down -> pulse with dir_o=11.
5. Hold enter for 20 cycles while tapping down -> exactly one enter_pulse; it coincides with step_pulse when the rises align. rep_en=0 while holding down 20 cycles -> only the initial pulse.
6. Assert rst for 2 cycles in REPEAT with up held -> all outputs at reset values. After rst drops with up still held -> step_pulse on the first cycle, dir_o=00, FSM in DELAY.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// Shared direction codes, FSM state encoding and priority helpers for ps2_key_cmd.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ps2_cmd_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } state_t;

    // v = {up, down, left, right}; fixed priority up > down > left > right
    function automatic logic [1:0] prio_dir(input logic [3:0] v);
        logic [1:0] d;
        if (v[3])      d = DIR_UP;
        else if (v[2]) d = DIR_DOWN;
        else if (v[1]) d = DIR_LEFT;
        else           d = DIR_RIGHT;
        return d;
    endfunction

    // Inverse of prio_dir for a single code: bit position in {up, down, left, right}
    function automatic logic [3:0] dir_mask(input logic [1:0] d);
        logic [3:0] m;
        m = 4'b1000 >> d;
        return m;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registers the key vector and exposes per-key rise/fall strobes.
// Latency: rise/fall are combinational against a 1-cycle-old copy of the keys.
// Backpressure: none, sampled every cycle.
module key_edge_det #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] k_q;

    always_ff @(posedge clk) begin
        if (rst) k_q <= '0;
        else     k_q <= key;
    end

    assign rise = key & ~k_q;
    assign fall = ~key & k_q;

endmodule

// File: rtl/ps2_key_cmd.sv
// Turns held PS/2 key levels into a latched direction, step pulses with auto-repeat, and enter pulses.
// Latency: all outputs registered, 1 cycle after the key is first sampled.
// Backpressure: none; consumer must take each one-cycle pulse when it appears.
module ps2_key_cmd
    import ps2_cmd_pkg::*;
#(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    input  logic       rep_en,
    output logic [1:0] dir_o,
    output logic       dir_valid,
    output logic       step_pulse,
    output logic       enter_pulse
);

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [4:0] key;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       unused_enter_fall;

    assign key = {up, down, left, right, enter};
    assign unused_enter_fall = fall[0];

    key_edge_det #(.W(5)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .rise (rise),
        .fall (fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic             step_q, step_d;
    logic             enter_q;

    logic [3:0] drise, dfall, dheld;
    logic       act_fall, terminal;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        drise    = rise[4:1];
        dfall    = fall[4:1];
        dheld    = key[4:1];
        act_fall = |(dfall & dir_mask(dir_q));
        terminal = (state_q == ST_DELAY) ? (cnt_q == DLY_LAST) : (cnt_q == RATE_LAST);

        if (state_q == ST_IDLE) begin
            if (|drise) begin
                dir_d   = prio_dir(drise);
                step_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_DELAY;
            end
        end else begin
            // A new press always wins, even if the active key drops in the same cycle
            if (|drise) begin
                dir_d   = prio_dir(drise);
                step_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_DELAY;
            end else if (act_fall) begin
                if (|dheld) begin
                    dir_d   = prio_dir(dheld);
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (rep_en) begin
                if (terminal) begin
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            step_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            enter_q <= rise[0];
        end
    end

    assign dir_o       = dir_q;
    assign dir_valid   = (state_q != ST_IDLE);
    assign step_pulse  = step_q;
    assign enter_pulse = enter_q;

endmodule
